// File: rtl/mdu_iter_pkg.sv
// Shared constants for the iterative multiply/divide unit: operand width,
// mul/div control codes, FSM encoding and an operand-magnitude helper.
package mdu_iter_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Two's-complement magnitude; 0x80000000 wraps to itself, which the
  // unsigned divider then treats correctly as 2^31.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// EX-stage to mul/div unit connection: request operands plus stall/done/result.
interface mdu_iter_if;
  import mdu_iter_pkg::*;

  logic              start;
  logic [4:0]        alucontrol;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              cancel;
  logic              stall;
  logic              done;
  logic [2*XLEN-1:0] hilo_out;

  modport master (
    output start, alucontrol, a, b, cancel,
    input  stall, done, hilo_out
  );

  modport slave (
    input  start, alucontrol, a, b, cancel,
    output stall, done, hilo_out
  );

endinterface

// File: rtl/mdu_iter_div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
// quo_next/rem_next expose the post-iteration values so the caller can capture the final step.
module mdu_iter_div_core
  import mdu_iter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next,
  output logic            last
);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  // The quotient register doubles as the dividend shift-out, so each step
  // pulls the next dividend bit into the partial remainder.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo_q[XLEN-2:0], 1'b0};
    end
    last = step && (cnt_q == CNT_W'(DIV_CYCLES - 1));
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvsr_d = divisor;
      cnt_d  = '0;
    end else if (abort) begin
      cnt_d  = '0;
    end else if (step) begin
      rem_d  = rem_next;
      quo_d  = quo_next;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// MULT/MULTU/DIV/DIVU unit feeding HI/LO: single-cycle multiply, 32-step divide.
// Owns the FSM, sign handling, product and the registered {hi,lo} result.
module mdu_iter
  import mdu_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);

  mdu_state_e        state_q, state_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dzero_q, dzero_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [2*XLEN-1:0] hilo_q, hilo_d;

  logic              is_mul, is_div, is_signed, accept;
  logic [2*XLEN-1:0] prod_s, prod_u, mul_result, div_result;
  logic [XLEN-1:0]   quo_mag, rem_mag, quo_fix, rem_fix;
  logic              div_last, div_step, div_abort;

  always_comb begin
    is_mul    = (bus.alucontrol == MULT_CONTROL) || (bus.alucontrol == MULTU_CONTROL);
    is_div    = (bus.alucontrol == DIV_CONTROL)  || (bus.alucontrol == DIVU_CONTROL);
    is_signed = (bus.alucontrol == MULT_CONTROL) || (bus.alucontrol == DIV_CONTROL);
    accept    = (state_q == ST_IDLE) && bus.start && !bus.cancel && (is_mul || is_div);
    div_step  = (state_q == ST_DIV) && !bus.cancel;
    div_abort = (state_q == ST_DIV) && bus.cancel;
  end

  always_comb begin
    prod_s     = $signed({{XLEN{bus.a[XLEN-1]}}, bus.a}) *
                 $signed({{XLEN{bus.b[XLEN-1]}}, bus.b});
    prod_u     = {{XLEN{1'b0}}, bus.a} * {{XLEN{1'b0}}, bus.b};
    mul_result = is_signed ? prod_s : prod_u;
  end

  mdu_iter_div_core u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && is_div),
    .step     (div_step),
    .abort    (div_abort),
    .dividend (magnitude(bus.a, is_signed)),
    .divisor  (magnitude(bus.b, is_signed)),
    .quo_next (quo_mag),
    .rem_next (rem_mag),
    .last     (div_last)
  );

  // Divide-by-zero bypasses the sign fix so the raw dividend lands in hi.
  always_comb begin
    quo_fix    = neg_quo_q ? (~quo_mag + 1'b1) : quo_mag;
    rem_fix    = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
    div_result = dzero_q ? {a_raw_q, {XLEN{1'b1}}} : {rem_fix, quo_fix};
  end

  always_comb begin
    state_d   = state_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dzero_d   = dzero_q;
    a_raw_d   = a_raw_q;
    hilo_d    = hilo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          hilo_d  = mul_result;
          state_d = ST_DONE;
        end else if (accept && is_div) begin
          neg_quo_d = is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
          neg_rem_d = is_signed && bus.a[XLEN-1];
          dzero_d   = (bus.b == '0);
          a_raw_d   = bus.a;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (div_last) begin
          hilo_d  = div_result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dzero_q   <= 1'b0;
      a_raw_q   <= '0;
      hilo_q    <= '0;
    end else begin
      state_q   <= state_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dzero_q   <= dzero_d;
      a_raw_q   <= a_raw_d;
      hilo_q    <= hilo_d;
    end
  end

  assign bus.stall    = rst && (accept || (state_q == ST_DIV));
  assign bus.done     = (state_q == ST_DONE) && !bus.cancel;
  assign bus.hilo_out = hilo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter: multiply, divide, signed corner cases,
// cancel, mid-divide reset and back-to-back operations.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mdu_iter_if bus ();

  mdu_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive_op(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.alucontrol = alu;
    bus.a          = a;
    bus.b          = b;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.alucontrol = 5'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
    n_checks++;
    if (bus.hilo_out !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_hilo: got %h expected 0", bus.hilo_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_done: got %b expected 0", bus.done); end
  endtask

  task automatic test_mult(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string name);
    @(negedge clk);
    drive_op(alu, a, b);
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL %s accept_stall: got %b expected 1", name, bus.stall); end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL %s done: got %b expected 1", name, bus.done); end
    n_checks++;
    if (bus.hilo_out !== exp) begin n_fail++; $display("[TB] FAIL %s hilo: got %h expected %h", name, bus.hilo_out, exp); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_stall: got %b expected 0", name, bus.stall); end
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_width: got %b expected 0", name, bus.done); end
  endtask

  task automatic test_div(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
    int lat;
    int stall_cnt;
    @(negedge clk);
    drive_op(alu, a, b);
    #1;
    stall_cnt = bus.stall ? 1 : 0;
    lat = 0;
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      @(negedge clk);
      if (bus.done) lat = cyc;
      else if (bus.stall) stall_cnt++;
      if (cyc == 1) bus.start = 1'b0;
    end
    n_checks++;
    if (lat != 33) begin n_fail++; $display("[TB] FAIL %s latency: got %0d expected 33", name, lat); end
    n_checks++;
    if (stall_cnt != 33) begin n_fail++; $display("[TB] FAIL %s stall_cycles: got %0d expected 33", name, stall_cnt); end
    n_checks++;
    if (bus.hilo_out !== exp) begin n_fail++; $display("[TB] FAIL %s hilo: got %h expected %h", name, bus.hilo_out, exp); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_stall: got %b expected 0", name, bus.stall); end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_width: got %b expected 0", name, bus.done); end
  endtask

  task automatic test_cancel();
    int done_cnt;
    @(negedge clk);
    drive_op(DIV_CONTROL, 32'd1000, 32'd3);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_div_stall: got %b expected 0", bus.stall); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_div_done: got %b expected 0", bus.done); end
    bus.cancel = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("[TB] FAIL cancel_div_no_done: got %0d expected 0", done_cnt); end
    test_mult(MULT_CONTROL, 32'd3, 32'd5, 64'd15, "mult_after_cancel");

    // start together with cancel in IDLE must not be accepted
    @(negedge clk);
    drive_op(DIV_CONTROL, 32'd9, 32'd3);
    bus.cancel = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_idle_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_idle_next_stall: got %b expected 0", bus.stall); end
    bus.start = 1'b0;
    bus.cancel = 1'b0;

    @(negedge clk);
    drive_op(MULTU_CONTROL, 32'd2, 32'd2);
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b1;
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_in_done: got %b expected 0", bus.done); end
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_after_done: got %b expected 0", bus.done); end
  endtask

  task automatic test_ignore();
    int done_cnt;
    @(negedge clk);
    drive_op(5'b00010, 32'd4, 32'd4);
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_stall: got %b expected 0", bus.stall); end
    done_cnt = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("[TB] FAIL ignore_done: got %0d expected 0", done_cnt); end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    int done_cnt;
    @(negedge clk);
    drive_op(DIVU_CONTROL, 32'd1000, 32'd3);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_stall: got %b expected 0", bus.stall); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_done: got %b expected 0", bus.done); end
    n_checks++;
    if (bus.hilo_out !== 64'd0) begin n_fail++; $display("[TB] FAIL midreset_hilo: got %h expected 0", bus.hilo_out); end
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int div_cyc;
    int mul_cyc;
    @(negedge clk);
    drive_op(DIV_CONTROL, 32'hFFFFFF9C, 32'd7);
    done_cnt = 0;
    div_cyc = 0;
    mul_cyc = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        if (div_cyc == 0) begin
          div_cyc = cyc;
          n_checks++;
          if (bus.hilo_out !== 64'hFFFFFFFE_FFFFFFF2) begin
            n_fail++; $display("[TB] FAIL b2b_div_hilo: got %h expected fffffffefffffff2", bus.hilo_out);
          end
          drive_op(MULT_CONTROL, 32'd6, 32'd7);
        end else begin
          if (mul_cyc == 0) mul_cyc = cyc;
          n_checks++;
          if (bus.hilo_out !== 64'd42) begin
            n_fail++; $display("[TB] FAIL b2b_mul_hilo: got %h expected 2a", bus.hilo_out);
          end
          bus.start = 1'b0;
        end
      end
    end
    n_checks++;
    if (done_cnt != 2) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    n_checks++;
    if (div_cyc != 33) begin n_fail++; $display("[TB] FAIL b2b_div_latency: got %0d expected 33", div_cyc); end
    n_checks++;
    if (mul_cyc != 35) begin n_fail++; $display("[TB] FAIL b2b_mul_cycle: got %0d expected 35", mul_cyc); end
  endtask

  initial begin
    test_reset();
    test_mult(MULT_CONTROL,  32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, "mult_neg");
    test_mult(MULTU_CONTROL, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
    test_div(DIVU_CONTROL, 32'd100,      32'd7,        64'h00000002_0000000E, "divu_100_7");
    test_div(DIV_CONTROL,  32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "div_neg7_2");
    test_div(DIV_CONTROL,  32'd100,      32'hFFFFFFF9, 64'h00000002_FFFFFFF2, "div_100_neg7");
    test_div(DIV_CONTROL,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_overflow");
    test_div(DIVU_CONTROL, 32'hFFFFFFFF, 32'd10,       64'h00000005_19999999, "divu_max_10");
    test_div(DIVU_CONTROL, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, "divu_by_zero");
    test_div(DIV_CONTROL,  32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, "div_neg_by_zero");
    test_cancel();
    test_ignore();
    test_reset_mid_div();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
